xor5_frame_checker: RTL and testbench
=====================================

XOR5_FRAME_CHECKER -- requirements
Module: xor5_frame_checker

Interface
Parameters:
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the frame word counter.
REQ-002 The block SHALL have parameter ODD_MODE, default 0; 0 selects even frame parity, 1 selects odd.
Ports:
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  5  data word; bit i corresponds to operand pi<i>.
REQ-008 in_last  input  1  marks the final word of a frame.
REQ-009 in_exp  input  1  expected frame parity; sampled only on the accepted in_last beat.
REQ-010 out_valid  output  1  frame result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_parity  output  1  computed frame parity.
REQ-013 out_error  output  1  computed parity differs from in_exp.
REQ-014 out_count  output  CNT_W  number of words in the frame, saturating.
REQ-015 out_ovf  output  1  frame word count exceeded 2^CNT_W-1.

Function
REQ-016 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 Word parity SHALL be the XOR of all five in_data bits.
REQ-018 Frame parity SHALL be the XOR of the word parities of all accepted words in the frame, XORed with ODD_MODE.
REQ-019 The FSM SHALL have three states: IDLE (no frame open), ACC (frame open), HOLD (result presented).
REQ-020 In IDLE and ACC, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0.
REQ-021 IDLE SHALL go to ACC on an accepted word with in_last=0.
REQ-022 IDLE SHALL go to HOLD on an accepted word with in_last=1; this is a single-word frame.
REQ-023 ACC SHALL go to HOLD on an accepted word with in_last=1, and SHALL remain in ACC otherwise.
REQ-024 HOLD SHALL go to IDLE on a cycle with out_ready=1.
REQ-025 HOLD SHALL hold out_* stable while out_ready=0.
REQ-026 out_valid SHALL be 1 exactly while in HOLD.
REQ-027 The first out_valid cycle SHALL be the cycle after the in_last beat is accepted (latency 1).
REQ-028 out_parity, out_error, out_count and out_ovf SHALL be registered and updated only on the HOLD entry edge.
REQ-029 out_error SHALL equal out_parity XOR in_exp, with in_exp sampled on the in_last beat.
REQ-030 The word counter SHALL restart at 1 on the first word of each frame, increment per accepted word, and saturate at 2^CNT_W-1.
REQ-031 out_ovf SHALL be 1 if an accept occurs while the counter is already saturated.
REQ-032 No word SHALL be accepted in the cycle that HOLD is released (no same-cycle turnaround).
REQ-033 The accumulator and counter SHALL clear on HOLD entry, ready for the next frame.
REQ-034 in_exp SHALL be ignored on non-last beats; in_data, in_last and in_exp SHALL be ignored when in_valid=0.

Reset
REQ-035 When rst_n=0, the block SHALL immediately set state to IDLE, clear accumulator and counter, and drive out_valid=0, out_parity=0, out_error=0, out_count=0, out_ovf=0, in_ready=0.
REQ-036 in_ready SHALL remain 0 while rst_n=0 and SHALL become 1 on the first clock edge after rst_n rises.
REQ-037 A frame in progress or a pending result when reset asserts SHALL be discarded without producing out_valid.

Verification
REQ-038 Three-word frame 5'b00001, 5'b00011, 5'b10111 with last=1, exp=1, ODD_MODE=0, out_ready=1 -> next cycle: out_valid=1, parity=1, error=0, count=3, ovf=0.
REQ-039 Single-word frame 5'b11111 with last=1, exp=0 -> next cycle: out_valid=1, parity=1, error=1, count=1.
REQ-040 Backpressure: hold out_ready=0 for 4 cycles after a result -> out_* stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle, then new frame accepted.
REQ-041 CNT_W=2, frame of 5 words -> count=3, ovf=1.
REQ-042 ODD_MODE=1, single word 5'b00000 with exp=1 -> parity=1, error=0.
REQ-043 Assert rst_n=0 mid-frame after 2 words, release, then send a 1-word frame 5'b00001 -> count=1, parity=1; no stale result appears.

Source files
------------

// File: rtl/xor5_frame_checker.sv
// Frame parity checker: XORs 5-bit words across a valid/ready frame,
// then presents parity, mismatch, word count and overflow until taken.
module xor5_frame_checker #(
    parameter int CNT_W    = 8,
    parameter int ODD_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_data,
    input  logic             in_last,
    input  logic             in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_error,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    localparam logic             ODD_BIT = 1'(ODD_MODE);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t             state_q, state_d;
    logic               en_q;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               par_q, par_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   ocnt_q, ocnt_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               wpar;
    logic               cnt_full;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_hit;
    logic               acc_nx;
    logic               par_nx;

    assign in_ready  = en_q && (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign wpar      = ^in_data;
    assign cnt_full  = &cnt_q;
    assign cnt_inc   = cnt_full ? cnt_q : cnt_q + ONE;
    assign ovf_hit   = sat_q | cnt_full;
    assign acc_nx    = acc_q ^ wpar;
    assign par_nx    = acc_nx ^ ODD_BIT;

    assign out_valid  = (state_q == HOLD);
    assign out_parity = par_q;
    assign out_error  = err_q;
    assign out_count  = ocnt_q;
    assign out_ovf    = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        par_d   = par_q;
        err_d   = err_q;
        ocnt_d  = ocnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    if (in_last) begin
                        // Results latch here; the running state is
                        // cleared so the next frame starts fresh.
                        state_d = HOLD;
                        par_d   = par_nx;
                        err_d   = par_nx ^ in_exp;
                        ocnt_d  = cnt_inc;
                        ovf_d   = ovf_hit;
                        acc_d   = 1'b0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                    end else begin
                        state_d = ACC;
                        acc_d   = acc_nx;
                        cnt_d   = cnt_inc;
                        sat_d   = ovf_hit;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            ocnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            par_q   <= par_d;
            err_q   <= err_d;
            ocnt_q  <= ocnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_xor5_frame_checker.sv
// Scoreboard bench for xor5_frame_checker over three parameterisations.
module tb_xor5_frame_checker;

    typedef struct packed {
        logic [1:0] id;
        logic       par;
        logic       err;
        logic [7:0] cnt;
        logic       ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      iv, il, ie, ordy;
    logic [2:0][4:0] idat;
    logic [2:0]      ir, ov, op, oe, oo;
    logic [2:0][7:0] oc;
    logic [1:0]      c2;
    int              checks = 0;
    int              failures = 0;
    exp_t            q[$];

    always #5 clk = ~clk;

    xor5_frame_checker #(.CNT_W(8), .ODD_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
        .in_last(il[0]), .in_exp(ie[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_parity(op[0]),
        .out_error(oe[0]), .out_count(oc[0]), .out_ovf(oo[0])
    );

    xor5_frame_checker #(.CNT_W(8), .ODD_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .in_last(il[1]), .in_exp(ie[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_parity(op[1]),
        .out_error(oe[1]), .out_count(oc[1]), .out_ovf(oo[1])
    );

    xor5_frame_checker #(.CNT_W(2), .ODD_MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2]),
        .in_last(il[2]), .in_exp(ie[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_parity(op[2]),
        .out_error(oe[2]), .out_count(c2), .out_ovf(oo[2])
    );

    assign oc[2] = {6'b0, c2};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push(input int d, input logic p, input logic e,
                        input logic [7:0] c, input logic o);
        exp_t x;
        x.id  = 2'(d);
        x.par = p;
        x.err = e;
        x.cnt = c;
        x.ovf = o;
        q.push_back(x);
    endtask

    task automatic send(input int d, input logic [4:0] w,
                        input logic last, input logic ex);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        iv[d]   = 1'b1;
        idat[d] = w;
        il[d]   = last;
        ie[d]   = ex;
        @(negedge clk);
        while (!ir[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk($sformatf("accept_timeout%0d", d), 0, 1);
        @(posedge clk);
        #1;
        iv[d]   = 1'b0;
        il[d]   = 1'b0;
        ie[d]   = 1'b0;
        idat[d] = '0;
        if (last) begin
            @(negedge clk);
            chk($sformatf("latency%0d", d), 32'(ov[d]), 1);
        end
    endtask

    // Monitor: pops on output handshake, checks stability under backpressure
    logic [2:0]       held;
    logic [2:0][10:0] snap;
    exp_t             e;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || !ov[i]) begin
                held[i] <= 1'b0;
            end else begin
                chk($sformatf("ready_in_hold%0d", i), 32'(ir[i]), 0);
                if (held[i])
                    chk($sformatf("stable%0d", i),
                        32'({op[i], oe[i], oc[i], oo[i]}), 32'(snap[i]));
                if (ordy[i]) begin
                    held[i] <= 1'b0;
                    if (q.size() == 0) begin
                        chk($sformatf("unexpected_result%0d", i), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("result_id", 32'(i), 32'(e.id));
                        chk($sformatf("parity%0d", i), 32'(op[i]), 32'(e.par));
                        chk($sformatf("error%0d", i), 32'(oe[i]), 32'(e.err));
                        chk($sformatf("count%0d", i), 32'(oc[i]), 32'(e.cnt));
                        chk($sformatf("ovf%0d", i), 32'(oo[i]), 32'(e.ovf));
                    end
                end else begin
                    held[i] <= 1'b1;
                    snap[i] <= {op[i], oe[i], oc[i], oo[i]};
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iv   = '0;
        il   = '0;
        ie   = '0;
        idat = '0;
        ordy = '1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), 32'(ov[i]), 0);
            chk($sformatf("rst_ready%0d", i), 32'(ir[i]), 0);
            chk($sformatf("rst_out%0d", i),
                32'({op[i], oe[i], oc[i], oo[i]}), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 32'(ir), 0);
        @(negedge clk);
        chk("ready_after_edge", 32'(ir), 32'h7);

        // three-word frame
        push(0, 1'b1, 1'b0, 8'd3, 1'b0);
        send(0, 5'b00001, 1'b0, 1'b0);
        send(0, 5'b00011, 1'b0, 1'b0);
        send(0, 5'b10111, 1'b1, 1'b1);

        // single word with backpressure and ignored input during hold
        @(posedge clk);
        #1 ordy[0] = 1'b0;
        push(0, 1'b1, 1'b1, 8'd1, 1'b0);
        send(0, 5'b11111, 1'b1, 1'b0);
        iv[0]   = 1'b1;
        idat[0] = 5'b10101;
        il[0]   = 1'b1;
        ie[0]   = 1'b1;
        repeat (4) @(posedge clk);
        #1 ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        il[0] = 1'b0;
        ie[0] = 1'b0;
        @(negedge clk);
        chk("released_valid", 32'(ov[0]), 0);
        chk("released_ready", 32'(ir[0]), 1);

        // new frame after release
        push(0, 1'b1, 1'b1, 8'd2, 1'b0);
        send(0, 5'b00110, 1'b0, 1'b0);
        send(0, 5'b01000, 1'b1, 1'b0);

        // odd parity mode
        push(1, 1'b1, 1'b0, 8'd1, 1'b0);
        send(1, 5'b00000, 1'b1, 1'b1);
        push(1, 1'b0, 1'b1, 8'd1, 1'b0);
        send(1, 5'b00001, 1'b1, 1'b1);

        // 2-bit counter saturation
        push(2, 1'b1, 1'b0, 8'd3, 1'b1);
        for (int k = 0; k < 4; k++) send(2, 5'b00001, 1'b0, 1'b0);
        send(2, 5'b00001, 1'b1, 1'b1);
        push(2, 1'b1, 1'b1, 8'd3, 1'b0);
        send(2, 5'b00011, 1'b0, 1'b0);
        send(2, 5'b00011, 1'b0, 1'b0);
        send(2, 5'b00111, 1'b1, 1'b0);

        // reset in the middle of a frame
        send(0, 5'b00001, 1'b0, 1'b0);
        send(0, 5'b00010, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ov[0]), 0);
        chk("midrst_ready", 32'(ir[0]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_held", 32'(ir[0]), 0);
        @(negedge clk);
        chk("midrst_ready_up", 32'(ir[0]), 1);
        push(0, 1'b1, 1'b0, 8'd1, 1'b0);
        send(0, 5'b00001, 1'b1, 1'b1);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
